board_store: RTL and testbench
==============================

// Module: board_store
// PURPOSE
//  Owns the 10x20 playfield occupancy map, directly downstream of the game FSM.
//  Accepts its one-cell-per-cycle lock writes and answers its collision reads
//  combinationally. Serves a second read port to the VGA renderer.
//  On request, runs a row-clear pass: removes every full row, shifts rows above down, counts lines.
// PARAMETERS
//  COLS     10  board width in cells (x = 0..COLS-1)
//  ROWS     20  board height in cells (y = 0..ROWS-1, y=0 top, gravity = y+1)
//  TOTAL_W  8   width of saturating lifetime line counter
// PORTS
//  CLOCK_50       in   1  single system clock, all state on posedge
//  reset          in   1  synchronous, active-high
//  wr_en          in   1  1-cycle write strobe
//  wr_x           in   4  write column
//  wr_y           in   5  write row
//  wr_data        in   1  1 = occupied, 0 = empty
//  rd_x           in   4  collision read column
//  rd_y           in   5  collision read row
//  rd_data        out  1  occupancy at (rd_x,rd_y), combinational
//  vga_x          in   4  renderer read column
//  vga_y          in   5  renderer read row
//  vga_data       out  1  occupancy at (vga_x,vga_y), combinational, 0 if out of range
//  clear_start    in   1  pulse: begin row-clear pass
//  clear_busy     out  1  high while pass in progress (state != IDLE)
//  clear_done     out  1  1-cycle pulse at end of pass
//  lines_cleared  out  5  rows removed by last pass (0..20), held until next pass
//  total_lines    out  TOTAL_W  lifetime rows removed, saturates at all-ones
// BEHAVIOUR
//  - Reset: all cells 0, state IDLE, clear_busy=0, clear_done=0, lines_cleared=0, total_lines=0.
//    Reset wins over any in-flight pass or write.
//  - Storage: ROWS registers of COLS bits. A write commits on the edge where wr_en=1 and is
//    visible on rd_data/vga_data the following cycle. There is no read-during-write bypass.
//  - Out-of-range write (wr_x>=COLS or wr_y>=ROWS): ignored.
//    Out-of-range rd: rd_data=1, so walls and floor read as solid.
//  - Writes are accepted only in IDLE; wr_en while clear_busy=1 is dropped.
//  - FSM states:
//    - IDLE: on clear_start go to SCAN with ptr=ROWS-1 and pass count=0.
//      A wr_en in that same cycle commits, so the scan sees it.
//    - SCAN, one row per cycle: if row[ptr] is all ones, row[k]<=row[k-1] for k=ptr..1,
//      row[0]<=0, count+1, ptr unchanged (the shifted-in row is rechecked). Otherwise
//      ptr-1. When ptr==0 and the row is not full, go to DONE.
//    - DONE (1 cycle): clear_done=1; lines_cleared<=count;
//      total_lines<=min(total_lines+count, 2^TOTAL_W-1); then IDLE.
//  - Pass latency: clear_start edge -> SCAN for exactly ROWS+N cycles (N rows removed)
//    -> DONE 1 cycle. clear_busy is high for ROWS+N+1 cycles.
//  - clear_start while busy: ignored. clear_start on the DONE cycle: ignored.
//  - ptr is a 5-bit down-counter. It never wraps below 0; the exit is on ptr==0 non-full.
//  - Arithmetic: count is 5 bits (max 20). The saturating add is computed at TOTAL_W+1 bits, then clamped.
// STRUCTURE
//  - Shared package: BOARD_COLS=10, BOARD_ROWS=20, X_W=4, Y_W=5, clear FSM state encodings
//    (S_CL_IDLE/SCAN/DONE). The game FSM and VGA renderer use the same constants.
//  - One sub-module: board_clear_fsm (state, ptr, count, done/saturation logic; outputs a
//    shift_row_en and shift_ptr). Row array, write port and both read muxes stay in board_store.
// TESTING
//  1. Reset -> all 200 cells read 0 on both ports; rd (10,0) -> 1; rd (0,20) -> 1; vga (10,0) -> 0.
//  2. Write (3,19)=1 -> rd (3,19)=0 same cycle, 1 next cycle; write (12,5)=1 -> no cell changes.
//  3. Fill row 19 plus cell (0,18), clear_start -> busy 22 cycles, clear_done once,
//     lines_cleared=1, (0,19)=1, row 18 empty, total_lines=1.
//  4. Rows 16..19 full, (5,15)=1 -> busy 25 cycles, lines_cleared=4, only (5,19) set,
//     total_lines +4.
//  5. Preload total_lines=253, clear 4 rows -> total_lines=255; a further 1-row clear stays 255.
//  6. Assert wr_en and clear_start mid-SCAN -> both ignored. Assert reset mid-SCAN -> next cycle
//     board all 0, busy=0, no clear_done.

Source files
------------

// File: rtl/board_store_pkg.sv
// Shared playfield constants and row-clear FSM encodings, used by the board,
// the game FSM and the VGA renderer.
package board_store_pkg;

  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 20;
  localparam int X_W        = 4;
  localparam int Y_W        = 5;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    S_CL_IDLE = 2'd0,
    S_CL_SCAN = 2'd1,
    S_CL_DONE = 2'd2
  } clr_state_e;

endpackage

// File: rtl/board_clear_fsm.sv
// Row-clear sequencer: walks rows bottom-up, requests a shift for each full row,
// and keeps the per-pass and saturating lifetime line counts.
module board_clear_fsm
  import board_store_pkg::*;
#(
  parameter int ROWS    = BOARD_ROWS,
  parameter int TOTAL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_start_i,
  input  logic               row_full_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               shift_row_en_o,
  output logic [Y_W-1:0]     shift_ptr_o,
  output logic [CNT_W-1:0]   lines_o,
  output logic [TOTAL_W-1:0] total_o
);

  clr_state_e           state_q, state_d;
  logic [Y_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     lines_q, lines_d;
  logic [TOTAL_W-1:0]   total_q, total_d;
  logic [TOTAL_W:0]     sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CL_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
      total_q <= total_d;
    end
  end

  // One extra bit catches the carry so the lifetime count clamps at all-ones.
  assign sum = {1'b0, total_q} + (TOTAL_W+1)'(cnt_q);

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    lines_d        = lines_q;
    total_d        = total_q;
    shift_row_en_o = 1'b0;
    done_o         = 1'b0;
    case (state_q)
      S_CL_IDLE: begin
        if (clear_start_i) begin
          state_d = S_CL_SCAN;
          ptr_d   = Y_W'(ROWS - 1);
          cnt_d   = '0;
        end
      end
      S_CL_SCAN: begin
        // A full row is shifted out and the same ptr rechecked next cycle.
        if (row_full_i) begin
          shift_row_en_o = 1'b1;
          cnt_d          = cnt_q + 1'b1;
        end else if (ptr_q == '0) begin
          state_d = S_CL_DONE;
        end else begin
          ptr_d = ptr_q - 1'b1;
        end
      end
      S_CL_DONE: begin
        done_o  = 1'b1;
        lines_d = cnt_q;
        total_d = sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
        state_d = S_CL_IDLE;
      end
      default: state_d = S_CL_IDLE;
    endcase
  end

  assign busy_o      = (state_q != S_CL_IDLE);
  assign shift_ptr_o = ptr_q;
  assign lines_o     = lines_q;
  assign total_o     = total_q;

endmodule

// File: rtl/board_store.sv
// Playfield occupancy map: one write port, a collision read port, a renderer
// read port, and a row-clear pass driven by board_clear_fsm.
module board_store
  import board_store_pkg::*;
#(
  parameter int COLS    = BOARD_COLS,
  parameter int ROWS    = BOARD_ROWS,
  parameter int TOTAL_W = 8
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [X_W-1:0]     wr_x,
  input  logic [Y_W-1:0]     wr_y,
  input  logic               wr_data,
  input  logic [X_W-1:0]     rd_x,
  input  logic [Y_W-1:0]     rd_y,
  output logic               rd_data,
  input  logic [X_W-1:0]     vga_x,
  input  logic [Y_W-1:0]     vga_y,
  output logic               vga_data,
  input  logic               clear_start,
  output logic               clear_busy,
  output logic               clear_done,
  output logic [CNT_W-1:0]   lines_cleared,
  output logic [TOTAL_W-1:0] total_lines
);

  logic [ROWS-1:0][COLS-1:0] rows_q, rows_d;
  logic                      shift_en;
  logic [Y_W-1:0]            shift_ptr;
  logic                      row_full;
  logic                      wr_in, rd_in, vga_in;

  assign wr_in  = (wr_x  < X_W'(COLS)) && (wr_y  < Y_W'(ROWS));
  assign rd_in  = (rd_x  < X_W'(COLS)) && (rd_y  < Y_W'(ROWS));
  assign vga_in = (vga_x < X_W'(COLS)) && (vga_y < Y_W'(ROWS));

  // Walls and floor read as solid for collision; the renderer sees empty.
  assign rd_data  = rd_in  ? rows_q[rd_y][rd_x]   : 1'b1;
  assign vga_data = vga_in ? rows_q[vga_y][vga_x] : 1'b0;
  assign row_full = &rows_q[shift_ptr];

  always_comb begin
    rows_d = rows_q;
    if (shift_en) begin
      for (int k = ROWS - 1; k > 0; k--) begin
        if (Y_W'(k) <= shift_ptr) rows_d[k] = rows_q[k-1];
      end
      rows_d[0] = '0;
    end else if (wr_en && !clear_busy && wr_in) begin
      rows_d[wr_y][wr_x] = wr_data;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) rows_q <= '0;
    else       rows_q <= rows_d;
  end

  board_clear_fsm #(
    .ROWS    (ROWS),
    .TOTAL_W (TOTAL_W)
  ) u_clear (
    .clk            (CLOCK_50),
    .reset          (reset),
    .clear_start_i  (clear_start),
    .row_full_i     (row_full),
    .busy_o         (clear_busy),
    .done_o         (clear_done),
    .shift_row_en_o (shift_en),
    .shift_ptr_o    (shift_ptr),
    .lines_o        (lines_cleared),
    .total_o        (total_lines)
  );

endmodule

// File: tb/tb_board_store.sv
// Bench for board_store: behavioural board model plus directed and random stimulus.
module tb_board_store;
  import board_store_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1, wr_en = 1'b0, wr_data = 1'b0, clear_start = 1'b0;
  logic [3:0] wr_x = '0, rd_x = '0, vga_x = '0;
  logic [4:0] wr_y = '0, rd_y = '0, vga_y = '0;
  logic       rd_data, vga_data, clear_busy, clear_done;
  logic [4:0] lines_cleared;
  logic [7:0] total_lines;

  board_store dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .vga_x(vga_x), .vga_y(vga_y), .vga_data(vga_data),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .lines_cleared(lines_cleared), .total_lines(total_lines)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int errors = 0, checks = 0;
  bit armed = 1'b0;

  // Model: board as rows of bits; a pass is resolved at start by filtering out
  // full rows, and its results land when the busy window (21+N cycles) ends.
  logic [9:0] mb[20];
  logic [9:0] nb[20];
  int m_left = 0, m_pend = 0, m_lines = 0, m_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_rd(input int x, input int y);
    if (x >= 10 || y >= 20) return 1'b1;
    return mb[y][x];
  endfunction

  function automatic logic model_vga(input int x, input int y);
    if (x >= 10 || y >= 20) return 1'b0;
    return mb[y][x];
  endfunction

  task automatic model_edge();
    int dst, n;
    if (reset) begin
      for (int y = 0; y < 20; y++) mb[y] = '0;
      m_left = 0; m_lines = 0; m_total = 0;
      return;
    end
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_lines = m_pend;
        m_total = (m_total + m_pend > 255) ? 255 : m_total + m_pend;
        for (int y = 0; y < 20; y++) mb[y] = nb[y];
      end
    end else begin
      if (wr_en && wr_x < 10 && wr_y < 20) mb[wr_y][wr_x] = wr_data;
      if (clear_start) begin
        dst = 19; n = 0;
        for (int y = 0; y < 20; y++) nb[y] = '0;
        for (int y = 19; y >= 0; y--) begin
          if (mb[y] == 10'h3FF) n++;
          else begin nb[dst] = mb[y]; dst--; end
        end
        m_pend = n;
        m_left = 21 + n;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    model_edge();
    #1;
  endtask

  always @(negedge CLOCK_50) begin
    if (armed) begin
      chk("busy",  32'(clear_busy),    32'(m_left > 0));
      chk("done",  32'(clear_done),    32'(m_left == 1));
      chk("lines", 32'(lines_cleared), 32'(m_lines));
      chk("total", 32'(total_lines),   32'(m_total));
      if (m_left == 0) begin
        chk("rd",  32'(rd_data),  32'(model_rd(int'(rd_x), int'(rd_y))));
        chk("vga", 32'(vga_data), 32'(model_vga(int'(vga_x), int'(vga_y))));
      end
    end
  end

  task automatic write_cell(input int x, input int y, input logic d);
    wr_en = 1'b1; wr_x = 4'(x); wr_y = 5'(y); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic fill_rows(input int lo, input int hi);
    for (int y = lo; y <= hi; y++)
      for (int x = 0; x < 10; x++) write_cell(x, y, 1'b1);
  endtask

  task automatic sweep();
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++) begin
        rd_x = 4'(x); rd_y = 5'(y); vga_x = 4'(9 - x); vga_y = 5'(19 - y);
        tick();
      end
  endtask

  task automatic run_pass(input int exp_busy, input int exp_lines, input string tag);
    int n, d;
    n = 0; d = 0;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    while (clear_busy === 1'b1 && n < 200) begin
      if (clear_done === 1'b1) d++;
      n++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
    chk({tag, "_done_pulses"}, 32'(d), 32'd1);
    chk({tag, "_lines"}, 32'(lines_cleared), 32'(exp_lines));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (clear_busy === 1'b1 && n < 200) begin n++; tick(); end
    chk({tag, "_idle_timeout"}, 32'(clear_busy), 32'd0);
  endtask

  initial begin
    for (int y = 0; y < 20; y++) begin mb[y] = '0; nb[y] = '0; end
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    armed = 1'b1;

    // Reset state and port boundaries
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++) begin
        rd_x = 4'(x); rd_y = 5'(y); vga_x = 4'(x); vga_y = 5'(y); #1;
        if (rd_data !== 1'b0 || vga_data !== 1'b0)
          chk("reset_cell", {30'd0, rd_data, vga_data}, 32'd0);
      end
    chk("reset_total", 32'(total_lines), 32'd0);
    rd_x = 4'd10; rd_y = 5'd0; vga_x = 4'd10; vga_y = 5'd0; #1;
    chk("rd_wall", 32'(rd_data), 32'd1);
    chk("vga_oob", 32'(vga_data), 32'd0);
    rd_x = 4'd0; rd_y = 5'd20; #1;
    chk("rd_floor", 32'(rd_data), 32'd1);

    // Write visibility and out-of-range write
    wr_en = 1'b1; wr_x = 4'd3; wr_y = 5'd19; wr_data = 1'b1;
    rd_x = 4'd3; rd_y = 5'd19; #1;
    chk("rd_same_cycle", 32'(rd_data), 32'd0);
    tick();
    wr_en = 1'b0; #1;
    chk("rd_next_cycle", 32'(rd_data), 32'd1);
    write_cell(12, 5, 1'b1);
    sweep();

    // Single-line clear
    fill_rows(19, 19);
    write_cell(0, 18, 1'b1);
    run_pass(22, 1, "one_line");
    chk("one_total", 32'(total_lines), 32'd1);
    rd_x = 4'd0; rd_y = 5'd19; #1;
    chk("one_dropped", 32'(rd_data), 32'd1);
    for (int x = 0; x < 10; x++) begin
      rd_x = 4'(x); rd_y = 5'd18; #1;
      if (rd_data !== 1'b0) chk("one_row18_empty", 32'(rd_data), 32'd0);
    end

    // Four-line clear
    write_cell(0, 19, 1'b0);
    fill_rows(16, 19);
    write_cell(5, 15, 1'b1);
    run_pass(25, 4, "four_line");
    chk("four_total", 32'(total_lines), 32'd5);
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++) begin
        rd_x = 4'(x); rd_y = 5'(y); #1;
        if (rd_data !== 1'((x == 5) && (y == 19)))
          chk("four_cell", 32'(rd_data), 32'((x == 5) && (y == 19)));
      end
    sweep();

    // Writes and clear_start mid-scan are dropped
    write_cell(5, 19, 1'b0);
    fill_rows(19, 19);
    clear_start = 1'b1; tick(); clear_start = 1'b0;
    repeat (5) tick();
    wr_en = 1'b1; wr_x = 4'd2; wr_y = 5'd10; wr_data = 1'b1; clear_start = 1'b1;
    tick();
    wr_en = 1'b0; clear_start = 1'b0;
    chk("mid_busy", 32'(clear_busy), 32'd1);
    wait_idle("mid");
    chk("mid_lines", 32'(lines_cleared), 32'd1);
    rd_x = 4'd2; rd_y = 5'd10; #1;
    chk("mid_write_dropped", 32'(rd_data), 32'd0);
    repeat (3) tick();

    // Reset mid-scan
    fill_rows(19, 19);
    clear_start = 1'b1; tick(); clear_start = 1'b0;
    repeat (3) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_busy", 32'(clear_busy), 32'd0);
    chk("rst_done", 32'(clear_done), 32'd0);
    chk("rst_total", 32'(total_lines), 32'd0);
    rd_x = 4'd4; rd_y = 5'd19; #1;
    chk("rst_cell", 32'(rd_data), 32'd0);
    sweep();

    // Saturation of the lifetime counter
    for (int p = 0; p < 12; p++) begin
      fill_rows(0, 19);
      run_pass(41, 20, "full_board");
    end
    fill_rows(7, 19);
    run_pass(34, 13, "thirteen");
    chk("sat_253", 32'(total_lines), 32'd253);
    fill_rows(16, 19);
    run_pass(25, 4, "sat_four");
    chk("sat_255", 32'(total_lines), 32'd255);
    fill_rows(19, 19);
    run_pass(22, 1, "sat_one");
    chk("sat_hold", 32'(total_lines), 32'd255);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 999) < 2);
      wr_en       = ($urandom_range(0, 99) < 70);
      wr_x        = 4'($urandom_range(0, 11));
      wr_y        = 5'($urandom_range(13, 21));
      wr_data     = ($urandom_range(0, 99) < 85);
      clear_start = ($urandom_range(0, 99) < 3);
      rd_x        = 4'($urandom_range(0, 15));
      rd_y        = 5'($urandom_range(0, 31));
      vga_x       = 4'($urandom_range(0, 15));
      vga_y       = 5'($urandom_range(0, 31));
      tick();
    end
    reset = 1'b0; wr_en = 1'b0; clear_start = 1'b0;
    wait_idle("final");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
